// File: rtl/usb_crc5_tx.sv
// usb_crc5_tx: serialises an 11-bit token/SOF field LSB-first, then appends
// the inverted USB CRC5 (x^5+x^2+1, seed 5'b11111) MSB-first.
// Optional build macro CRC5_SELFCHECK_EN: keeps the LFSR running over the
// transmitted CRC bits and flags a bad residual on self_err.
module usb_crc5_tx #(
  parameter int unsigned DATA_BITS = 11
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] token_field,
  input  logic                 shift_en,
  output logic                 tx_bit,
  output logic                 busy,
  output logic [4:0]           crc_out,
  output logic                 done
`ifdef CRC5_SELFCHECK_EN
  ,
  output logic                 self_err
`endif
);

  localparam int unsigned CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC,
    ST_DONE
  } state_t;

  state_t               state_q,   state_d;
  logic [DATA_BITS-1:0] shreg_q,   shreg_d;
  logic [4:0]           lfsr_q,    lfsr_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]           crc_cnt_q, crc_cnt_d;
  logic [4:0]           crc_out_q, crc_out_d;
`ifdef CRC5_SELFCHECK_EN
  logic                 self_err_q, self_err_d;
`endif

  logic                 fb;
  logic [4:0]           lfsr_step;

  // Output decode from registered state only.
  always_comb begin
    tx_bit = 1'b0;
    case (state_q)
      ST_DATA: tx_bit = shreg_q[0];
      ST_CRC:  tx_bit = crc_out_q[crc_cnt_q];
      default: tx_bit = 1'b0;
    endcase
  end

  assign busy    = (state_q == ST_DATA) || (state_q == ST_CRC);
  assign done    = (state_q == ST_DONE);
  assign crc_out = crc_out_q;
`ifdef CRC5_SELFCHECK_EN
  assign self_err = self_err_q;
`endif

  // One serial CRC5 step over the bit currently on the wire.
  always_comb begin
    fb        = lfsr_q[4] ^ tx_bit;
    lfsr_step = {lfsr_q[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    lfsr_d    = lfsr_q;
    bit_cnt_d = bit_cnt_q;
    crc_cnt_d = crc_cnt_q;
    crc_out_d = crc_out_q;
`ifdef CRC5_SELFCHECK_EN
    self_err_d = self_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d   = token_field;
          lfsr_d    = '1;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
`ifdef CRC5_SELFCHECK_EN
          self_err_d = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        if (shift_en) begin
          lfsr_d    = lfsr_step;
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
            crc_out_d = ~lfsr_step;
            crc_cnt_d = 3'd4;
            state_d   = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        if (shift_en) begin
`ifdef CRC5_SELFCHECK_EN
          lfsr_d = lfsr_step;
`endif
          crc_cnt_d = crc_cnt_q - 3'd1;
          if (crc_cnt_q == 3'd0) begin
            crc_cnt_d = 3'd0;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
`ifdef CRC5_SELFCHECK_EN
        self_err_d = (lfsr_q != 5'b01100);
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      lfsr_q    <= '1;
      bit_cnt_q <= '0;
      crc_cnt_q <= '0;
      crc_out_q <= '0;
`ifdef CRC5_SELFCHECK_EN
      self_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      lfsr_q    <= lfsr_d;
      bit_cnt_q <= bit_cnt_d;
      crc_cnt_q <= crc_cnt_d;
      crc_out_q <= crc_out_d;
`ifdef CRC5_SELFCHECK_EN
      self_err_q <= self_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_usb_crc5_tx.sv
// Directed bench for usb_crc5_tx with hand-computed CRC5 vectors.
module tb_usb_crc5_tx;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [10:0] token_field;
  logic        shift_en;
  logic        tx_bit;
  logic        busy;
  logic [4:0]  crc_out;
  logic        done;
`ifdef CRC5_SELFCHECK_EN
  logic        self_err;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  usb_crc5_tx #(.DATA_BITS(11)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .token_field (token_field),
    .shift_en    (shift_en),
    .tx_bit      (tx_bit),
    .busy        (busy),
    .crc_out     (crc_out),
    .done        (done)
`ifdef CRC5_SELFCHECK_EN
    ,
    .self_err    (self_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // seq[i] is the i-th bit expected on the wire (16 bits total).
  task automatic send_pkt(input logic [10:0] f, input logic [15:0] seq,
                          input logic [4:0] crc, input int unsigned gap,
                          input bit poke);
    token_field = f;
    start       = 1'b1;
    shift_en    = 1'b1;  // must be ignored in IDLE
    step();
    start       = 1'b0;
    shift_en    = 1'b0;
    token_field = '0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < int'(gap); g++) begin
        chk("tx_hold", 32'(tx_bit), 32'(seq[i]));
        chk("busy_hold", 32'(busy), 32'd1);
        step();
      end
      shift_en = 1'b1;
      if (poke && i == 4) begin
        start       = 1'b1;
        token_field = 11'h2AA;
      end
      chk("tx_bit", 32'(tx_bit), 32'(seq[i]));
      chk("busy", 32'(busy), 32'd1);
      step();
      shift_en    = 1'b0;
      start       = 1'b0;
      token_field = '0;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("tx_in_done", 32'(tx_bit), 32'd0);
    chk("crc_out", 32'(crc_out), 32'(crc));
    if (poke) begin
      start       = 1'b1;
      token_field = 11'h555;
      shift_en    = 1'b1;
    end
    step();
    start       = 1'b0;
    shift_en    = 1'b0;
    token_field = '0;
    chk("done_cleared", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("crc_hold", 32'(crc_out), 32'(crc));
`ifdef CRC5_SELFCHECK_EN
    chk("self_err", 32'(self_err), 32'd0);
`endif
  endtask

  initial begin
    n_rst       = 1'b0;
    start       = 1'b0;
    shift_en    = 1'b0;
    token_field = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx", 32'(tx_bit), 32'd0);
    chk("rst_crc", 32'(crc_out), 32'd0);
    n_rst = 1'b1;
    step();

    // All-zero field, strobe every cycle: CRC 5'b01000.
    send_pkt(11'h000, 16'h1000, 5'b01000, 0, 1'b0);
    // {endp=E, addr=15}: CRC 5'b10111, strobe every 4th cycle.
    send_pkt(11'h715, 16'hEF15, 5'b10111, 3, 1'b0);
    // Field 1: CRC 5'b10111, start poked mid-DATA and in DONE.
    send_pkt(11'h001, 16'hE801, 5'b10111, 0, 1'b1);
    // Back-to-back right after the poked DONE, with gaps.
    send_pkt(11'h000, 16'h1000, 5'b01000, 2, 1'b1);

    // Asynchronous reset in the middle of DATA.
    token_field = 11'h715;
    start       = 1'b1;
    step();
    start       = 1'b0;
    chk("pre_rst_tx", 32'(tx_bit), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_tx", 32'(tx_bit), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_crc", 32'(crc_out), 32'd0);
    step();
    chk("rst_no_done", 32'(done), 32'd0);
    n_rst = 1'b1;
    step();
    send_pkt(11'h715, 16'hEF15, 5'b10111, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
